mem_arbiter: RTL and testbench

Shares the single 32x8 instruction/data memory between the VeriRISC CPU datapath and a debug/loader port. Debug accesses are granted only at instruction boundaries or while the CPU is halted. The phase counter is frozen at phase 0 through `cpu_hold` for the duration of debug ownership. A burst limit guarantees the CPU retires at least one instruction between debug bursts.

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the shared 32x8 VeriRISC memory between the CPU datapath and a debug/loader port.
// Debug ownership is granted only at instruction boundaries (phase 7) or while the CPU is halted.
module mem_arbiter #(
    parameter int unsigned AWIDTH    = 5,
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        phase,
    input  logic              cpu_halt,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [AWIDTH-1:0] dbg_addr,
    input  logic [DWIDTH-1:0] dbg_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              dbg_ack,
    output logic [DWIDTH-1:0] dbg_rdata
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

    typedef enum logic [2:0] {
        CpuRun,
        DbgHold,
        DbgAccess,
        DbgDone,
        DbgAck
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     burst_q, burst_d;
    logic                we_q, we_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic                hold_q, hold_d;
    logic                ack_q, ack_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            CpuRun: begin
                if (dbg_req && (phase == 3'd7 || cpu_halt)) begin
                    state_d = DbgHold;
                    burst_d = '0;
                end
            end
            DbgHold: begin
                // Once the burst budget is spent a running CPU gets the memory back.
                if (dbg_req && (burst_q < MaxCnt || cpu_halt)) begin
                    state_d = DbgAccess;
                    we_d    = dbg_we;
                    addr_d  = dbg_addr;
                    wdata_d = dbg_wdata;
                end else begin
                    state_d = CpuRun;
                end
            end
            DbgAccess: begin
                state_d = DbgDone;
                if (burst_q != MaxCnt) begin
                    burst_d = burst_q + CntW'(1);
                end
            end
            DbgDone: begin
                state_d = DbgAck;
                if (!we_q) begin
                    rdata_d = mem_rdata;
                end
            end
            DbgAck: begin
                state_d = DbgHold;
            end
            default: begin
                state_d = CpuRun;
            end
        endcase

        hold_d = (state_d != CpuRun);
        ack_d  = (state_d == DbgAck);
    end

    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        unique case (state_q)
            CpuRun: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_rd    = cpu_rd;
                mem_wr    = cpu_wr;
            end
            DbgAccess: begin
                mem_rd = !we_q;
                mem_wr = we_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CpuRun;
            burst_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign cpu_hold  = hold_q;
    assign dbg_ack   = ack_q;
    assign dbg_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: phase counter and memory are modelled around the DUT,
// debug transactions are predicted from the grant/burst rules and a reference memory image.
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    phase;
    logic          cpu_halt = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_rd = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dbg_req = 1'b0;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_hold;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] mem     [32];
    logic [DW-1:0] ref_mem [32];
    bit            m_held = 1'b0;
    int            m_served = 0;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .phase     (phase),
        .cpu_halt  (cpu_halt),
        .cpu_addr  (cpu_addr),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_wdata (cpu_wdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    // CPU phase counter (enable = !cpu_hold) and the synchronous-read memory.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) phase <= '0;
        else if (!cpu_hold) phase <= phase + 3'd1;
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // Ack cycle of a transaction whose request is first presented in cycle t0 at phase p.
    function automatic int predict(input int t0, input int p, input bit held, input bit halt,
                                   output bit fresh, output int low);
        if (held && (halt || m_served < MB)) begin
            fresh = 1'b0;
            low   = 0;
            return t0 + 3;
        end
        fresh = 1'b1;
        if (held) begin
            low = 8 - p;
            return t0 + 12 - p;
        end
        if (halt) begin
            low = 1;
            return t0 + 4;
        end
        low = 8 - p;
        return t0 + 11 - p;
    endfunction

    task automatic rand_cpu;
        cpu_addr  = AW'($urandom);
        cpu_rd    = 1'($urandom);
        cpu_wr    = 1'b0;
        cpu_wdata = DW'($urandom);
    endtask

    task automatic idle(input int n);
        dbg_req = 1'b0;
        repeat (n) begin
            @(negedge clk);
            rand_cpu();
        end
        m_held = 1'b0;
    endtask

    // Presents one debug request and observes it until dbg_ack (bounded).
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input bit keep, output int ack_at, output logic [DW-1:0] rd_ack,
                         output int n_rd, output int n_wr, output logic [AW-1:0] s_addr,
                         output logic [DW-1:0] s_wdata, output int n_low, output int n_badph,
                         output logic [2:0] ph_ack);
        bit         done;
        bit         prev_hold;
        logic [2:0] prev_ph;
        done = 1'b0; prev_hold = 1'b0; prev_ph = '0;
        ack_at = -1; rd_ack = 'x; n_rd = 0; n_wr = 0; s_addr = 'x; s_wdata = 'x;
        n_low = 0; n_badph = 0; ph_ack = 'x;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
        for (int k = 0; k < 60 && !done; k++) begin
            #1;
            if (cpu_hold) begin
                if (mem_rd) begin n_rd++; s_addr = mem_addr; end
                if (mem_wr) begin n_wr++; s_addr = mem_addr; s_wdata = mem_wdata; end
                if (prev_hold && phase !== prev_ph) n_badph++;
            end else begin
                n_low++;
            end
            prev_hold = cpu_hold;
            prev_ph   = phase;
            if (dbg_ack) begin
                ack_at = cyc; rd_ack = dbg_rdata; ph_ack = phase; done = 1'b1;
                if (!keep) dbg_req = 1'b0;
            end
            @(negedge clk);
            rand_cpu();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cpu_addr = 5'h15; cpu_wdata = 8'h3C; cpu_rd = 1'b1; cpu_wr = 1'b0;
        #1;
        checks++;
        if (cpu_hold !== 1'b0 || dbg_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: cpu_hold=%b dbg_ack=%b, required 0 0", cpu_hold, dbg_ack);
        end
        checks++;
        if (dbg_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: got %h, required 00", dbg_rdata);
        end
        checks++;
        if ({mem_addr, mem_rd, mem_wr, mem_wdata} !== {5'h15, 1'b1, 1'b0, 8'h3C}) begin
            errors++;
            $display("FAIL reset_mem: got %h/%b/%b/%h, required 15/1/0/3c",
                     mem_addr, mem_rd, mem_wr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        m_held = 1'b0; m_served = 0;
        idle(2);
    endtask

    task automatic test_passthrough;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          r, w;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a = AW'($urandom); d = DW'($urandom); r = 1'($urandom); w = 1'($urandom);
            cpu_addr = a; cpu_wdata = d; cpu_rd = r; cpu_wr = w; cpu_halt = 1'($urandom);
            #1;
            checks++;
            if (cpu_hold !== 1'b0 || dbg_ack !== 1'b0 ||
                {mem_addr, mem_rd, mem_wr, mem_wdata} !== {a, r, w, d}) begin
                errors++;
                $display("FAIL passthrough: hold=%b ack=%b mem=%h/%b/%b/%h, required 0 0 %h/%b/%b/%h",
                         cpu_hold, dbg_ack, mem_addr, mem_rd, mem_wr, mem_wdata, a, r, w, d);
            end
        end
        cpu_halt = 1'b0;
    endtask

    task automatic preload;
        logic [DW-1:0] v;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            v = (a == 'h1A) ? 8'h5C : DW'($urandom);
            cpu_addr = AW'(a); cpu_wdata = v; cpu_wr = 1'b1; cpu_rd = 1'b0;
            ref_mem[a] = v;
        end
        idle(2);
    endtask

    task automatic test_read_phase3;
        int t0, ack, low, exp, elow, nrd, nwr, badph, guard;
        logic [DW-1:0] rd, sw;
        logic [AW-1:0] sa;
        logic [2:0]    pa;
        bit fresh;
        cpu_halt = 1'b0;
        guard = 0;
        while (phase !== 3'd3 && guard < 20) begin @(negedge clk); rand_cpu(); guard++; end
        checks++;
        if (phase !== 3'd3) begin
            errors++;
            $display("FAIL wait_phase3: phase=%0d, required 3 within 20 cycles", phase);
        end
        t0  = cyc;
        exp = predict(t0, int'(phase), m_held, 1'b0, fresh, elow);
        issue(1'b0, 5'h1A, 8'h00, 1'b0, ack, rd, nrd, nwr, sa, sw, low, badph, pa);
        m_served = fresh ? 1 : m_served + 1;
        checks++;
        if (ack !== exp) begin
            errors++;
            $display("FAIL rd3_ack_cycle: ack at %0d, required %0d", ack, exp);
        end
        checks++;
        if (rd !== 8'h5C) begin
            errors++;
            $display("FAIL rd3_data: got %h, required 5c", rd);
        end
        checks++;
        if (nrd != 1 || nwr != 0 || sa !== 5'h1A) begin
            errors++;
            $display("FAIL rd3_strobe: rd=%0d wr=%0d addr=%h, required 1 0 1a", nrd, nwr, sa);
        end
        checks++;
        if (low != elow || badph != 0 || pa !== 3'd0) begin
            errors++;
            $display("FAIL rd3_phase_hold: run=%0d moved=%0d phase=%0d, required %0d 0 0",
                     low, badph, pa, elow);
        end
        #1;
        checks++;
        if (cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL rd3_hold_after_ack: cpu_hold=%b, required 1", cpu_hold);
        end
        @(negedge clk);
        #1;
        checks++;
        if (cpu_hold !== 1'b0 || phase !== 3'd0) begin
            errors++;
            $display("FAIL rd3_release: cpu_hold=%b phase=%0d, required 0 0", cpu_hold, phase);
        end
        @(negedge clk);
        #1;
        checks++;
        if (phase !== 3'd1) begin
            errors++;
            $display("FAIL rd3_phase_resume: phase=%0d, required 1", phase);
        end
        idle(2);
    endtask

    task automatic test_write_read;
        int t0, ack1, ack2, low, exp1, exp2, elow, nrd, nwr, badph;
        logic [DW-1:0] rd, sw;
        logic [AW-1:0] sa;
        logic [2:0]    pa;
        bit fresh;
        idle(1 + int'($urandom % 8));
        t0   = cyc;
        exp1 = predict(t0, int'(phase), m_held, 1'b0, fresh, elow);
        issue(1'b1, 5'h03, 8'hA5, 1'b1, ack1, rd, nrd, nwr, sa, sw, low, badph, pa);
        m_served = fresh ? 1 : m_served + 1; m_held = 1'b1;
        checks++;
        if (ack1 !== exp1 || nwr != 1 || nrd != 0 || sa !== 5'h03 || sw !== 8'hA5) begin
            errors++;
            $display("FAIL wr_txn: ack=%0d wr=%0d rd=%0d addr=%h data=%h, required %0d 1 0 03 a5",
                     ack1, nwr, nrd, sa, sw, exp1);
        end
        ref_mem[3] = 8'hA5;
        t0   = cyc;
        exp2 = predict(t0, int'(phase), m_held, 1'b0, fresh, elow);
        issue(1'b0, 5'h03, 8'h00, 1'b0, ack2, rd, nrd, nwr, sa, sw, low, badph, pa);
        m_served = fresh ? 1 : m_served + 1;
        checks++;
        if (ack2 !== exp2 || ack2 - ack1 != 4) begin
            errors++;
            $display("FAIL wr_rd_spacing: acks at %0d,%0d, required %0d,%0d", ack1, ack2, exp1,
                     exp1 + 4);
        end
        checks++;
        if (rd !== 8'hA5 || nrd != 1 || sa !== 5'h03) begin
            errors++;
            $display("FAIL wr_rd_data: got %h rd=%0d addr=%h, required a5 1 03", rd, nrd, sa);
        end
        idle(2);
    endtask

    task automatic test_store_at_grant;
        int t0, ack, low, exp, elow, nrd, nwr, badph, guard;
        logic [DW-1:0] rd, sw, d;
        logic [AW-1:0] sa, a;
        logic [2:0]    pa;
        bit fresh;
        guard = 0;
        while (phase !== 3'd6 && guard < 20) begin @(negedge clk); rand_cpu(); guard++; end
        @(negedge clk);
        checks++;
        if (phase !== 3'd7) begin
            errors++;
            $display("FAIL wait_phase7: phase=%0d, required 7 within 21 cycles", phase);
        end
        a = AW'($urandom); d = DW'($urandom);
        cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1; cpu_rd = 1'b0;
        t0  = cyc;
        exp = predict(t0, int'(phase), m_held, 1'b0, fresh, elow);
        issue(1'b0, a, 8'h00, 1'b0, ack, rd, nrd, nwr, sa, sw, low, badph, pa);
        m_served = fresh ? 1 : m_served + 1;
        ref_mem[a] = d;
        checks++;
        if (ack !== exp || rd !== d) begin
            errors++;
            $display("FAIL store_at_grant: ack=%0d data=%h, required %0d %h", ack, rd, exp, d);
        end
        idle(2);
    endtask

    task automatic test_burst;
        int t0, ack, low, exp, elow, nrd, nwr, badph, acks;
        logic [DW-1:0] rd, sw, wd;
        logic [AW-1:0] sa, a;
        logic [2:0]    pa;
        logic          we;
        bit fresh;
        cpu_halt = 1'b0;
        acks = 0;
        idle(1 + int'($urandom % 8));
        for (int i = 0; i < 6; i++) begin
            we = 1'($urandom); a = AW'($urandom); wd = DW'($urandom);
            t0  = cyc;
            exp = predict(t0, int'(phase), m_held, 1'b0, fresh, elow);
            issue(we, a, wd, i < 5, ack, rd, nrd, nwr, sa, sw, low, badph, pa);
            m_served = fresh ? 1 : m_served + 1; m_held = 1'b1;
            if (ack >= 0) acks++;
            checks++;
            if (ack !== exp || low != elow) begin
                errors++;
                $display("FAIL burst_timing[%0d]: ack=%0d run=%0d, required %0d %0d",
                         i, ack, low, exp, elow);
            end
            checks++;
            if (we ? (nwr != 1 || nrd != 0 || sa !== a || sw !== wd)
                   : (nrd != 1 || nwr != 0 || sa !== a || rd !== ref_mem[a])) begin
                errors++;
                $display("FAIL burst_data[%0d]: we=%b rd=%0d wr=%0d addr=%h wd=%h rdata=%h, required addr %h wd %h rdata %h",
                         i, we, nrd, nwr, sa, sw, rd, a, wd, ref_mem[a]);
            end
            if (we) ref_mem[a] = wd;
        end
        checks++;
        if (acks != 6) begin
            errors++;
            $display("FAIL burst_acks: got %0d, required 6", acks);
        end
        idle(2);
    endtask

    task automatic test_halt_b2b;
        int t0, ack, prev_ack, low, exp, elow, nrd, nwr, badph;
        logic [DW-1:0] rd, sw, wd;
        logic [AW-1:0] sa, a;
        logic [2:0]    pa;
        logic          we;
        bit fresh;
        idle(1 + int'($urandom % 8));
        cpu_halt = 1'b1;
        prev_ack = -1;
        for (int i = 0; i < 6; i++) begin
            we = 1'($urandom); a = AW'($urandom); wd = DW'($urandom);
            t0  = cyc;
            exp = predict(t0, int'(phase), m_held, 1'b1, fresh, elow);
            issue(we, a, wd, i < 5, ack, rd, nrd, nwr, sa, sw, low, badph, pa);
            m_served = fresh ? 1 : m_served + 1; m_held = 1'b1;
            checks++;
            if (ack !== exp || low != elow || (prev_ack >= 0 && ack - prev_ack != 4)) begin
                errors++;
                $display("FAIL halt_timing[%0d]: ack=%0d prev=%0d run=%0d, required %0d %0d",
                         i, ack, prev_ack, low, exp, elow);
            end
            checks++;
            if (we ? (nwr != 1 || sa !== a || sw !== wd) : (nrd != 1 || rd !== ref_mem[a])) begin
                errors++;
                $display("FAIL halt_data[%0d]: we=%b addr=%h wd=%h rdata=%h, required %h %h %h",
                         i, we, sa, sw, rd, a, wd, ref_mem[a]);
            end
            if (we) ref_mem[a] = wd;
            prev_ack = ack;
        end
        cpu_halt = 1'b0;
        idle(2);
    endtask

    task automatic test_random;
        int t0, ack, low, exp, elow, nrd, nwr, badph;
        logic [DW-1:0] rd, sw, wd;
        logic [AW-1:0] sa, a;
        logic [2:0]    pa;
        logic          we;
        bit fresh, keep, halt;
        for (int i = 0; i < 24; i++) begin
            we = 1'($urandom); a = AW'($urandom); wd = DW'($urandom);
            halt = ($urandom % 4) == 0;
            keep = (i < 23) && (($urandom % 3) != 0);
            cpu_halt = halt;
            t0  = cyc;
            exp = predict(t0, int'(phase), m_held, halt, fresh, elow);
            issue(we, a, wd, keep, ack, rd, nrd, nwr, sa, sw, low, badph, pa);
            m_served = fresh ? 1 : m_served + 1; m_held = 1'b1;
            checks++;
            if (ack !== exp || low != elow || badph != 0) begin
                errors++;
                $display("FAIL rand_timing[%0d]: ack=%0d run=%0d moved=%0d, required %0d %0d 0",
                         i, ack, low, badph, exp, elow);
            end
            checks++;
            if (we ? (nwr != 1 || nrd != 0 || sa !== a || sw !== wd)
                   : (nrd != 1 || nwr != 0 || sa !== a || rd !== ref_mem[a])) begin
                errors++;
                $display("FAIL rand_data[%0d]: we=%b rd=%0d wr=%0d addr=%h wd=%h rdata=%h, required addr %h wd %h rdata %h",
                         i, we, nrd, nwr, sa, sw, rd, a, wd, ref_mem[a]);
            end
            if (we) ref_mem[a] = wd;
            if (!keep) idle(1 + int'($urandom % 4));
        end
        cpu_halt = 1'b0;
        idle(2);
    endtask

    task automatic test_reset_mid;
        int bad;
        cpu_halt = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'h1A; dbg_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (cpu_hold !== 1'b1 || dbg_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre_reset: cpu_hold=%b dbg_ack=%b, required 1 0", cpu_hold, dbg_ack);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; dbg_req = 1'b0; cpu_halt = 1'b0;
        cpu_addr = 5'h0B; cpu_wdata = 8'h66; cpu_rd = 1'b1; cpu_wr = 1'b0;
        #1;
        checks++;
        if (cpu_hold !== 1'b0 || dbg_ack !== 1'b0 || dbg_rdata !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_state: hold=%b ack=%b rdata=%h, required 0 0 00",
                     cpu_hold, dbg_ack, dbg_rdata);
        end
        checks++;
        if ({mem_addr, mem_rd, mem_wr, mem_wdata} !== {5'h0B, 1'b1, 1'b0, 8'h66}) begin
            errors++;
            $display("FAIL mid_reset_mem: got %h/%b/%b/%h, required 0b/1/0/66",
                     mem_addr, mem_rd, mem_wr, mem_wdata);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rand_cpu();
            #1;
            if (dbg_ack !== 1'b0 || cpu_hold !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_reset_after: %0d cycles with ack or hold, required 0", bad);
        end
        m_held = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        preload();
        test_read_phase3();
        test_write_read();
        test_store_at_grant();
        test_burst();
        test_halt_b2b();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, required completion within 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
